// File: rtl/matrix_mac_pkg.sv
// Shared types for the 4x4 matrix multiply-accumulate sequencer and its datapath.
package matrix_mac_pkg;

    localparam int unsigned MAT_DIM = 4;
    localparam int unsigned MAT_DW  = 8;

    // One 4x4 tile of MAT_DW-bit elements, indexed [row][col].
    typedef logic [0:MAT_DIM-1][0:MAT_DIM-1][MAT_DW-1:0] mat_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        CAPTURE,
        OUT
    } seq_state_e;

endpackage

// File: rtl/matrix_mac_seq.sv
// Sequencer for the 4x4 matrix MAC datapath: clears the accumulator, streams K
// operand tile-pairs into the MAC, captures the result and offers it downstream.
// Optional build macro MATRIX_MAC_SEQ_STALL_CNT_EN adds a 16-bit stall_cnt output
// counting input stalls during accumulation.
module matrix_mac_seq
    import matrix_mac_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_K      = 16,
    localparam int unsigned KW         = $clog2(MAX_K + 1)
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [KW-1:0]                                      cfg_k,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    in_a,
    input  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    in_b,
    output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    mac_matrix_1,
    output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    mac_matrix_2,
    output logic                                               mac_enable,
    output logic                                               mac_clear,
    input  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    mac_result,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]    out_result,
    output logic                                               busy,
    output logic                                               done
`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                                        stall_cnt
`endif
);

    localparam logic [KW-1:0] KMax = KW'(MAX_K);

    seq_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0] out_result_q, out_result_d;

    // Next-state: job latch, beat counting and result capture.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        beat_d       = beat_q;
        out_result_d = out_result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Oversized counts are clamped so the beat counter always terminates.
                    k_d     = (cfg_k > KMax) ? KMax : cfg_k;
                    beat_d  = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (k_q != '0) ? ACCUM : CAPTURE;
            end
            ACCUM: begin
                if (in_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == k_q - 1'b1) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                // MAC is idle this cycle, so its output is the final accumulator.
                out_result_d = mac_result;
                state_d      = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            beat_q       <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            beat_q       <= beat_d;
            out_result_q <= out_result_d;
        end
    end

    // Outputs decoded from the registered state; operands pass through only in ACCUM.
    always_comb begin
        in_ready     = (state_q == ACCUM);
        mac_enable   = in_ready & in_valid;
        mac_clear    = (state_q == CLEAR);
        mac_matrix_1 = in_ready ? in_a : '0;
        mac_matrix_2 = in_ready ? in_b : '0;
        out_valid    = (state_q == OUT);
        out_result   = out_result_q;
        busy         = (state_q != IDLE);
        done         = out_valid & out_ready;
    end

`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: restarts per job, saturates, holds after accumulation ends.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == CLEAR) begin
            stall_cnt_d = '0;
        end else if ((state_q == ACCUM) && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Self-checking bench for matrix_mac_seq with a behavioural MAC unit and a
// timing/result reference model. Honours MATRIX_MAC_SEQ_STALL_CNT_EN.
module tb_matrix_mac_seq;
    import matrix_mac_pkg::*;

    localparam int DW   = 8;
    localparam int MAXK = 16;
    localparam int KW   = $clog2(MAXK + 1);

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    mat_t          in_a = '0;
    mat_t          in_b = '0;
    mat_t          mac_matrix_1, mac_matrix_2, mac_result, out_result;
    logic          mac_enable, mac_clear, out_valid, busy, done;
    logic          out_ready = 1'b0;
`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clock = ~clock;

    matrix_mac_seq #(
        .DATA_WIDTH(DW),
        .MAX_K     (MAXK)
    ) dut (
        .clock       (clock),
        .reset       (rst_n),
        .start       (start),
        .cfg_k       (cfg_k),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mac_matrix_1(mac_matrix_1),
        .mac_matrix_2(mac_matrix_2),
        .mac_enable  (mac_enable),
        .mac_clear   (mac_clear),
        .mac_result  (mac_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy),
        .done        (done)
`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mat_t mat_mul(input mat_t a, input mat_t b);
        mat_t r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[i][k]) * int'(b[k][j]);
                r[i][j] = 8'(s);
            end
        end
        return r;
    endfunction

    function automatic mat_t mat_add(input mat_t a, input mat_t b);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = a[i][j] + b[i][j];
        return r;
    endfunction

    function automatic mat_t mat_fill(input logic [7:0] v);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = v;
        return r;
    endfunction

    function automatic mat_t mat_ident();
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = (i == j) ? 8'd1 : 8'd0;
        return r;
    endfunction

    function automatic mat_t mat_rand();
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = 8'($urandom);
        return r;
    endfunction

    // Behavioural MAC unit, sharing reset with the sequencer.
    mat_t acc;
    always @(posedge clock) begin
        if (!rst_n)          acc <= '0;
        else if (mac_clear)  acc <= '0;
        else if (mac_enable) acc <= mat_add(acc, mat_mul(mac_matrix_1, mac_matrix_2));
    end
    assign mac_result = acc;

    // Reference model: job timeline expressed as cycle numbers relative to the start.
    int   cyc = 0;
    bit   m_on = 1'b0;
    int   m_t0, m_k, m_beats, m_outv_from, m_stalls;
    mat_t m_res;

    function automatic bit e_clear();
        return m_on && (cyc == m_t0 + 1);
    endfunction
    function automatic bit e_ready();
        return m_on && (cyc >= m_t0 + 2) && (m_beats < m_k);
    endfunction
    function automatic bit e_outv();
        return m_on && (cyc >= m_outv_from);
    endfunction

    always @(posedge clock) begin
        if (!rst_n) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            if (start) begin
                m_on        = 1'b1;
                m_t0        = cyc;
                m_k         = (int'(cfg_k) > MAXK) ? MAXK : int'(cfg_k);
                m_beats     = 0;
                m_stalls    = 0;
                m_res       = '0;
                m_outv_from = (m_k == 0) ? cyc + 3 : 32'h7fff_ffff;
            end
        end else begin
            if (e_ready()) begin
                if (in_valid) begin
                    m_res = mat_add(m_res, mat_mul(in_a, in_b));
                    m_beats++;
                    if (m_beats == m_k) m_outv_from = cyc + 2;
                end else begin
                    m_stalls++;
                end
            end
            if (e_outv() && out_ready) m_on = 1'b0;
        end
        cyc++;
    end

    // Per-cycle compare of every DUT output against the model.
    bit chk_on = 1'b0;
    always @(negedge clock) begin
        if (chk_on) begin
            chk("in_ready", in_ready, e_ready());
            chk("mac_enable", mac_enable, e_ready() && in_valid);
            chk("mac_clear", mac_clear, e_clear());
            chk("mac_matrix_1", mac_matrix_1, e_ready() ? in_a : '0);
            chk("mac_matrix_2", mac_matrix_2, e_ready() ? in_b : '0);
            chk("out_valid", out_valid, e_outv());
            chk("done", done, e_outv() && out_ready);
            chk("busy", busy, m_on);
            if (e_outv()) begin
                chk("out_result", out_result, m_res);
`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, m_stalls[15:0]);
`endif
            end
        end
    end

    // Runs one job; reports DUT event times (relative to the start cycle) and counts.
    task automatic run_job(input int k, input bit ident, input logic [7:0] v,
                           input logic [31:0] mask, input bit rnd, input int hold,
                           input bit pulse, output int clr_rel, output int en_rel,
                           output int ov_rel, output int en_cnt, output int ov_cnt,
                           output int done_cnt);
        int t0, held, rel, j;
        bit fin;
        clr_rel = -1; en_rel = -1; ov_rel = -1;
        en_cnt = 0; ov_cnt = 0; done_cnt = 0; held = 0; fin = 1'b0;
        t0 = cyc;
        start = 1'b1;
        cfg_k = k[KW-1:0];
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int b = 0; b < 300; b++) begin
            @(negedge clock);
            rel = cyc - t0;
            if (mac_clear && clr_rel < 0) clr_rel = rel;
            if (mac_enable) begin
                en_cnt++;
                if (en_rel < 0) en_rel = rel;
            end
            if (out_valid) begin
                ov_cnt++;
                if (ov_rel < 0) ov_rel = rel;
            end
            if (done) done_cnt++;
            @(posedge clock);
            #1;
            if (!m_on) begin
                fin = 1'b1;
                break;
            end
            start = pulse && e_outv();
            rel = cyc - t0;
            j = rel - 2;
            if (rnd) in_valid = ($urandom_range(0, 3) != 0);
            else     in_valid = !(j >= 0 && j < 32 && mask[j]);
            if (ident) begin
                in_a = mat_ident();
                in_b = mat_fill(v);
            end else begin
                in_a = mat_rand();
                in_b = mat_rand();
            end
            if (e_outv()) begin
                if (held < hold) begin
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
            end else begin
                out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL job_timeout: got job still running after 300 cycles, expected completion");
        end
    endtask

    int clr_rel, en_rel, ov_rel, en_cnt, ov_cnt, done_cnt;
    mat_t first_res;

    initial begin
        // Reset, then idle.
        @(posedge clock);
        #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mac_clear", mac_clear, 1'b0);
        chk("rst_out_result", out_result, 128'd0);
`ifdef MATRIX_MAC_SEQ_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
        @(posedge clock);
        #1;

        // K=1, A=I, B=2s, no stalls.
        run_job(1, 1'b1, 8'd2, 32'd0, 1'b0, 0, 1'b0, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("k1_clear_cycle", clr_rel, 1);
        chk("k1_enable_cycle", en_rel, 2);
        chk("k1_outv_cycle", ov_rel, 4);
        chk("k1_enable_count", en_cnt, 1);
        chk("k1_model_result", m_res, mat_fill(8'd2));

        // K=3, A=I, B=1s, two stall cycles inside ACCUM.
        run_job(3, 1'b1, 8'd1, 32'b00101, 1'b0, 0, 1'b0, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("k3_enable_count", en_cnt, 3);
        chk("k3_outv_cycle", ov_rel, 8);
        chk("k3_model_result", m_res, mat_fill(8'd3));
        chk("k3_model_stalls", m_stalls, 2);

        // K=0: straight to capture, zero result.
        run_job(0, 1'b0, 8'd0, 32'd0, 1'b0, 0, 1'b0, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("k0_enable_count", en_cnt, 0);
        chk("k0_outv_cycle", ov_rel, 3);
        chk("k0_model_result", m_res, 128'd0);

        // Output back-pressure for 4 cycles with start pulsed during OUT.
        run_job(2, 1'b0, 8'd0, 32'd0, 1'b0, 4, 1'b1, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("hold_outv_cycles", ov_cnt, 5);
        chk("hold_done_count", done_cnt, 1);
        @(negedge clock);
        chk("hold_busy_after", busy, 1'b0);
        @(posedge clock);
        #1;

        // Oversized count clamps to MAX_K.
        run_job(20, 1'b0, 8'd0, 32'd0, 1'b0, 0, 1'b0, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("clamp_enable_count", en_cnt, MAXK);
        chk("clamp_outv_cycle", ov_rel, MAXK + 3);

        // Reset during ACCUM after 2 of 4 beats, then a fresh K=2 job.
        start = 1'b1;
        cfg_k = KW'(4);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_a = mat_rand();
            in_b = mat_rand();
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clock);
        #1;
        run_job(2, 1'b0, 8'd0, 32'd0, 1'b0, 0, 1'b0, clr_rel, en_rel, ov_rel, en_cnt,
                ov_cnt, done_cnt);
        chk("midrst_enable_count", en_cnt, 2);
        chk("midrst_outv_cycle", ov_rel, 5);

        // Randomized jobs: random counts, stalls, back-pressure and stray starts.
        for (int n = 0; n < 30; n++) begin
            int k;
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31))
                                            : int'($urandom_range(0, MAXK));
            run_job(k, 1'b0, 8'd0, 32'd0, 1'b1, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 1) == 1), clr_rel, en_rel, ov_rel, en_cnt, ov_cnt,
                    done_cnt);
            chk("rand_enable_count", en_cnt, (k > MAXK) ? MAXK : k);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_mac_seq.md
# matrix_mac_seq

Sequencer for the 4x4 matrix multiply-accumulate datapath. It accepts a start command with an accumulation count K, then takes K operand tile-pairs (A,B) over a valid/ready stream and drives them into the MAC unit. It clears the MAC accumulator before the first tile, captures the accumulated 4x4 result after the K-th tile, and presents it on a valid/ready output port. It sits between the tile fetch logic and the MAC datapath; the parent instantiates both side by side.

## Interface
- DATA_WIDTH, 8, element width of operand and result matrices
- MAX_K, 16, largest accumulation count; KW = $clog2(MAX_K+1)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- cfg_k  in  KW  accumulation count, latched with start
- in_valid  in  1  operand tile-pair valid
- in_ready  out  1  operand tile-pair accepted when in_valid & in_ready
- in_a, in_b  in  [DATA_WIDTH-1:0] [0:3][0:3]  operand matrices
- mac_matrix_1, mac_matrix_2  out  [DATA_WIDTH-1:0] [0:3][0:3]  to MAC operands
- mac_enable  out  1  MAC accumulate this cycle
- mac_clear  out  1  MAC accumulator clear this cycle
- mac_result  in  [DATA_WIDTH-1:0] [0:3][0:3]  from MAC result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  [DATA_WIDTH-1:0] [0:3][0:3]  registered result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on output handshake

## Operation
- States: IDLE, CLEAR, ACCUM, CAPTURE, OUT.
- IDLE: if start, latch cfg_k into k_reg, zero beat counter, and go to CLEAR. start in any other state is ignored.
- CLEAR: mac_clear=1 for exactly one cycle. Next state is ACCUM if k_reg != 0, else CAPTURE.
- ACCUM: in_ready=1. mac_matrix_1/2 = in_a/in_b combinationally. mac_enable = in_valid & in_ready. Each handshake increments the beat counter. On the handshake where beat == k_reg-1, go to CAPTURE. in_valid=0 is a stall: state holds and mac_enable=0.
- CAPTURE: mac_enable=0, so mac_result equals the accumulator. Register out_result <= mac_result, then go to OUT.
- OUT: out_valid=1, out_result held stable. When out_ready=1, pulse done and go to IDLE.
- Outside ACCUM: in_ready=0, mac_enable=0, and mac_matrix_1/2 are driven to zero.
- Arithmetic belongs to the MAC unit and wraps modulo 2^DATA_WIDTH. The sequencer does not inspect values.
- cfg_k > MAX_K is clamped to MAX_K at latch time.
- Reset values: state=IDLE, in_ready=0, mac_enable=0, mac_clear=0, mac_matrix_1/2=0, out_valid=0, out_result=all zero, busy=0, done=0, k_reg=0, beat=0.
- Reset asserted mid-job: the job is discarded and the sequencer returns to IDLE next cycle. The MAC unit shares reset, so no clear is issued.

## Timing
- start sampled at edge 0 → CLEAR in cycle 1 → ACCUM from cycle 2.
- With no stalls, the K-th beat lands in cycle K+1, CAPTURE in cycle K+2, and out_valid first high in cycle K+3.
- K=0: CLEAR cycle 1, CAPTURE cycle 2, out_valid cycle 3, result all zero.
- out_valid stays high until the handshake. done is high in the handshake cycle. busy drops the cycle after.
- A start in the same cycle as the output handshake is ignored: the state is still OUT. A new start is accepted from the next cycle.
- Back-to-back jobs have a minimum of K+4 cycles start-to-start.

## Configuration
- Macro MATRIX_MAC_SEQ_STALL_CNT_EN.
- Defined: adds an output stall_cnt, 16 bits. It is cleared in CLEAR and increments on each ACCUM cycle with in_valid=0, saturating at 16'hFFFF. It holds its value until the next job's CLEAR, and its reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package matrix_mac_pkg holds:
  - MAT_DIM=4
  - typedef mat_t (DATA_WIDTH element 4x4 array)
  - the state enum seq_state_e {IDLE, CLEAR, ACCUM, CAPTURE, OUT}
- No sub-module. Single FSM plus beat counter and result register. The MAC datapath is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle 5 cycles → all outputs at reset values, busy=0.
- cfg_k=1, A=identity, B=all 2s, no stalls → mac_clear cycle 1, mac_enable cycle 2, out_valid cycle 4, out_result all 2s.
- cfg_k=3, identical A=identity, B=all 1s, in_valid low on 2 ACCUM cycles → exactly 3 mac_enable pulses, out_result all 3s; stall_cnt=2 when the macro is defined.
- cfg_k=0 → no mac_enable, out_valid cycle 3, out_result all zero.
- out_ready held low 4 cycles after out_valid, with start pulsed meanwhile → out_result stable, start ignored, done pulses on handshake, busy low next cycle.
- reset driven low in ACCUM after 2 of 4 beats → IDLE next cycle, in_ready=0; a new job with cfg_k=2 then completes correctly.
